// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path
// (scheduler FSM states, digit count and scan length).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } sched_state_t;

    localparam int DIGITS          = 8;
    localparam int CYCLES_PER_SCAN = 8;

endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps, so the most recently granted source is considered last.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] grant_idx
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                valid     = 1'b1;
                grant_idx = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Shares the 8-digit display engine between NUM_REQ value sources: grants one
// source round-robin, holds its value for HOLD_SCANS full scans, then rearbitrates.
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HOLD_SCANS = 4,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    input  logic                  shift_strobe,
    output logic                  write_ready,
    output logic                  rollover_flag,
    output logic [31:0]           writeback,
    output logic                  busy,
    output logic [SRC_W-1:0]      cur_src
);

    localparam logic [7:0] LAST_SCAN = 8'(HOLD_SCANS - 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [7:0]       scan_cnt;
    logic [SRC_W-1:0] rr_ptr;
    logic             grant_valid;
    logic [SRC_W-1:0] grant_idx;
    logic [31:0]      grant_data;

    rr_arbiter #(.N(NUM_REQ)) u_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .valid     (grant_valid),
        .grant_idx (grant_idx)
    );

    assign grant_data = req_data[32*int'(grant_idx) +: 32];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid) state_next = LOAD;
            LOAD:    state_next = SHOW;
            SHOW:    if (shift_strobe && scan_cnt == LAST_SCAN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state so no input reaches an output combinationally.
    always_comb begin
        req_ack       = '0;
        write_ready   = 1'b0;
        rollover_flag = 1'b0;
        busy          = 1'b0;
        unique case (state)
            LOAD: begin
                req_ack[cur_src] = 1'b1;
                write_ready      = 1'b1;
                busy             = 1'b1;
            end
            SHOW: begin
                busy          = 1'b1;
                rollover_flag = (scan_cnt == LAST_SCAN);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            writeback <= '0;
            scan_cnt  <= '0;
            rr_ptr    <= SRC_W'(NUM_REQ - 1);
            cur_src   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: if (grant_valid) begin
                    writeback <= grant_data;
                    cur_src   <= grant_idx;
                    rr_ptr    <= grant_idx;
                    scan_cnt  <= '0;
                end
                SHOW: if (shift_strobe && scan_cnt != LAST_SCAN) begin
                    scan_cnt <= scan_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: the bench plays the display engine,
// issuing shift_strobe every CYCLES_PER_SCAN cycles while the scheduler shows a value.
module tb_display_scheduler;
    import display_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [3:0]   req = '0;
    logic [127:0] req_data = '0;
    logic         shift_strobe = 1'b0;
    logic [3:0]   req_ack;
    logic         write_ready;
    logic         rollover_flag;
    logic [31:0]  writeback;
    logic         busy;
    logic [1:0]   cur_src;

    logic [3:0]   req1 = '0;
    logic [127:0] req_data1 = '0;
    logic         shift_strobe1 = 1'b0;
    logic [3:0]   req_ack1;
    logic         write_ready1;
    logic         rollover_flag1;
    logic [31:0]  writeback1;
    logic         busy1;
    logic [1:0]   cur_src1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_scheduler #(.NUM_REQ(4), .HOLD_SCANS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .shift_strobe  (shift_strobe),
        .write_ready   (write_ready),
        .rollover_flag (rollover_flag),
        .writeback     (writeback),
        .busy          (busy),
        .cur_src       (cur_src)
    );

    display_scheduler #(.NUM_REQ(4), .HOLD_SCANS(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .req           (req1),
        .req_data      (req_data1),
        .req_ack       (req_ack1),
        .shift_strobe  (shift_strobe1),
        .write_ready   (write_ready1),
        .rollover_flag (rollover_flag1),
        .writeback     (writeback1),
        .busy          (busy1),
        .cur_src       (cur_src1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called in the first SHOW cycle; drives HOLD_SCANS=4 scans and ends in the IDLE cycle after.
    task automatic showScans(input string tag, input logic [31:0] wb);
        for (int k = 1; k <= 4; k++) begin
            repeat (CYCLES_PER_SCAN) tick();
            shift_strobe = 1'b1;
            checkOutput({tag, " rollover"}, 32'(rollover_flag), 32'(k == 4));
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " writeback"}, writeback, wb);
            tick();
            shift_strobe = 1'b0;
        end
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " rollover off"}, 32'(rollover_flag), 32'd0);
    endtask

    // Called in an IDLE cycle with req already applied; checks LOAD then SHOW entry.
    task automatic checkGrant(input string tag, input int src, input logic [31:0] wb);
        checkOutput({tag, " idle before"}, 32'(busy), 32'd0);
        tick();
        checkOutput({tag, " ack"}, 32'(req_ack), 32'(4'b0001 << src));
        checkOutput({tag, " write_ready"}, 32'(write_ready), 32'd1);
        checkOutput({tag, " cur_src"}, 32'(cur_src), 32'(src));
        checkOutput({tag, " writeback"}, writeback, wb);
        tick();
        checkOutput({tag, " ack one cycle"}, 32'(req_ack), 32'd0);
        checkOutput({tag, " write_ready one cycle"}, 32'(write_ready), 32'd0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        req_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        req_data1 = {32'hB000_0003, 32'h1234_5678, 32'hB000_0001, 32'hB000_0000};

        // Reset values.
        #2;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset req_ack", 32'(req_ack), 32'd0);
        checkOutput("reset write_ready", 32'(write_ready), 32'd0);
        checkOutput("reset rollover", 32'(rollover_flag), 32'd0);
        checkOutput("reset writeback", writeback, 32'd0);
        checkOutput("reset cur_src", 32'(cur_src), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single source 1 with spurious strobes during IDLE and LOAD.
        req_data[63:32] = 32'hDEAD_BEEF;
        req             = 4'b0010;
        shift_strobe    = 1'b1;
        checkOutput("single idle", 32'(busy), 32'd0);
        tick();
        checkOutput("single ack", 32'(req_ack), 32'b0010);
        checkOutput("single write_ready", 32'(write_ready), 32'd1);
        checkOutput("single writeback", writeback, 32'hDEAD_BEEF);
        req = 4'b0000;
        tick();
        shift_strobe = 1'b0;
        checkOutput("single ack dropped", 32'(req_ack), 32'd0);
        checkOutput("single rollover start", 32'(rollover_flag), 32'd0);
        showScans("single", 32'hDEAD_BEEF);
        repeat (3) tick();
        checkOutput("single stays idle", 32'(busy), 32'd0);

        // All four requesting from reset: strict rotation 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_data[63:32] = 32'hA000_0001;
        req             = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            checkGrant($sformatf("rr%0d", g), order[g], 32'hA000_0000 | 32'(order[g]));
            showScans($sformatf("rr%0d", g), 32'hA000_0000 | 32'(order[g]));
        end
        req = 4'b0000;
        tick();

        // Asynchronous reset in the middle of the second scan.
        req = 4'b0100;
        checkGrant("pre-rst", 2, 32'hA000_0002);
        req = 4'b0000;
        repeat (CYCLES_PER_SCAN) tick();
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst rollover", 32'(rollover_flag), 32'd0);
        checkOutput("midrst writeback", writeback, 32'd0);
        checkOutput("midrst cur_src", 32'(cur_src), 32'd0);
        rst = 1'b0;
        req = 4'b0001;
        checkGrant("post-rst", 0, 32'hA000_0000);
        showScans("post-rst", 32'hA000_0000);

        // Source 0 stays high; source 3 arrives during SHOW and must win next.
        checkGrant("late0", 0, 32'hA000_0000);
        req = 4'b1001;
        showScans("late0", 32'hA000_0000);
        checkGrant("late3", 3, 32'hA000_0003);
        req = 4'b0000;
        showScans("late3", 32'hA000_0003);

        // HOLD_SCANS=1: rollover spans the whole SHOW phase.
        req1 = 4'b0100;
        tick();
        checkOutput("hold1 ack", 32'(req_ack1), 32'b0100);
        req1 = 4'b0000;
        tick();
        checkOutput("hold1 rollover first", 32'(rollover_flag1), 32'd1);
        checkOutput("hold1 writeback", writeback1, 32'h1234_5678);
        repeat (CYCLES_PER_SCAN) tick();
        checkOutput("hold1 rollover last", 32'(rollover_flag1), 32'd1);
        shift_strobe1 = 1'b1;
        tick();
        shift_strobe1 = 1'b0;
        checkOutput("hold1 idle", 32'(busy1), 32'd0);
        checkOutput("hold1 rollover off", 32'(rollover_flag1), 32'd0);
        checkOutput("hold1 cur_src", 32'(cur_src1), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
